uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit UART TX. It adds configurable data width, baud divider, stop-bit count and an input FIFO, so the host can queue words without waiting on Busy. It serialises each queued word as start bit, data bits LSB-first, optional parity, then stop bit(s). It sits between the host register interface and the TX pad.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9)
CLKS_PER_BIT, 16, clk cycles per serial bit (legal >= 1)
STOP_BITS, 1, stop bits per frame (legal 1 or 2)
FIFO_DEPTH, 4, word entries in the input FIFO (power of two, >= 2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel word to transmit
DATA_VALID  input  1  host write strobe
PAR_EN  input  1  parity enable; sampled together with P_DATA
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA
DATA_READY  output  1  FIFO not full; a write is accepted only when high
TX_OUT  output  1  serial line, registered, idle high
Busy  output  1  high for every cycle of a frame (start through last stop)

Behaviour:
- Reset (reset=1 at a rising edge): TX_OUT=1, Busy=0, DATA_READY=1, FIFO emptied, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame at once. No partial bits or stop bits are sent.
- Write: {PAR_TYP, PAR_EN, P_DATA} is pushed on an edge where DATA_VALID=1 and DATA_READY=1. DATA_READY is !full as registered before the edge. A write while full is dropped, even if a pop occurs on the same edge.
- Simultaneous push and pop: allowed when not full. Occupancy stays unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If the FIFO is non-empty, pop at the edge, load the shift register and parity config, and go to START. TX_OUT=0 and Busy=1 take effect from that same edge.
- Latency: a word written at edge E into an empty FIFO while IDLE drives the start bit from edge E+1.
- Bit timing: each bit holds TX_OUT for exactly CLKS_PER_BIT cycles. A bit-period counter runs 0..CLKS_PER_BIT-1 and wraps at the bit boundary.
- START: 1 bit of 0, then DATA.
- DATA: DATA_WIDTH bits, LSB first. A bit-index counter selects each bit. After the last bit, go to PARITY if PAR_EN=1, otherwise STOP.
- Parity bit:
  - even (PAR_TYP=0): XOR of the data bits
  - odd (PAR_TYP=1): inverted XOR of the data bits
- STOP: STOP_BITS bits of 1, Busy held high throughout.
- End of the final stop-bit cycle:
  - FIFO non-empty: pop and go directly to START; the next start bit follows with no idle cycle and Busy stays 1.
  - FIFO empty: go to IDLE; Busy=0 from that edge.
- Frame length in cycles: CLKS_PER_BIT*(1+DATA_WIDTH+PAR_EN+STOP_BITS).
- Changes on P_DATA, PAR_EN or PAR_TYP never affect a word already queued or in flight.
- TX_OUT and Busy are glitch-free flop outputs.

Test Plan:
(DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, FIFO_DEPTH=4 unless stated.)
- Reset: hold reset=1 for 2 cycles -> TX_OUT=1, Busy=0, DATA_READY=1; no activity for 20 idle cycles.
- Even parity: write P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 at edge E -> from E+1, TX_OUT emits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. Busy=1 for exactly 44 cycles, then 0.
- Odd parity, no-parity: write 8'h03, PAR_EN=1, PAR_TYP=1 -> parity bit=1, 44-cycle frame. Write 8'h03, PAR_EN=0 -> no parity slot, 40-cycle frame.
- FIFO fill: 6 writes on consecutive edges while idle, PAR_EN=0.
  - First 5 are accepted; 6th is dropped with DATA_READY=0 at that edge.
  - 5 frames go out back-to-back; Busy stays high for 200 continuous cycles.
  - Frame data matches write order.
- STOP_BITS=2 instance: write 8'hFF, PAR_EN=0 -> stop level high for 8 cycles, 44-cycle frame. A second queued word starts on the cycle right after the stop bits.
- Reset mid-frame: 2 words queued; assert reset during the DATA bit 3 period -> next edge TX_OUT=1, Busy=0, DATA_READY=1. The queued word is never sent; a new write afterwards transmits normally.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO of queued words.
// Each word is framed as: start bit, DATA_WIDTH data bits sent LSB first,
// an optional parity bit, then STOP_BITS stop bits.
// Parity enable and parity type are captured with each word when it is
// written, so later changes on the host inputs never alter queued frames.
//
// Handshake: a write is accepted on a rising edge where DATA_VALID=1 and
// DATA_READY=1. DATA_READY is !full, decoded from the registered occupancy.
// A write while full is dropped, even if a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  DATA_READY,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            state_dbg
);

    localparam int EW = DATA_WIDTH + 2;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and pointers; each entry is {par_typ, par_en, data}
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Transmit path
    state_t                state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          cnt_last;
    logic [EW-1:0] head;

    assign full     = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = DATA_VALID && !full;
    assign head     = mem_q[rd_ptr_q];
    assign cnt_last = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

    assign DATA_READY = !full;
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;
    assign state_dbg  = state_q;

    // FIFO next-state: write at the tail, advance the head on pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {PAR_TYP, PAR_EN, P_DATA};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers; storage needs no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    // Frame FSM: next state, bit timing and registered line/busy levels
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == IW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_last) begin
                    clk_cnt_d  = '0;
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Popping a word starts its start bit on this same edge
        if (pop) begin
            state_d   = S_START;
            clk_cnt_d = '0;
            shift_d   = head[DATA_WIDTH-1:0];
            par_en_d  = head[DATA_WIDTH];
            par_bit_d = (^head[DATA_WIDTH-1:0]) ^ head[DATA_WIDTH+1];
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    // Frame FSM registers; reset aborts any frame in flight immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: instance A (1 stop bit) and
// instance B (2 stop bits), both 8 data bits and 4 clocks per bit.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;

    logic [7:0] a_data;
    logic       a_valid, a_pe, a_pt;
    logic       a_ready, a_tx, a_busy;
    logic [2:0] a_state;

    logic [7:0] b_data;
    logic       b_valid, b_pe, b_pt;
    logic       b_ready, b_tx, b_busy;
    logic [2:0] b_state;

    int checks;
    int errors;

    // Expected serial bits, one entry per bit period, in line order
    logic [0:0] exp_q[$];

    uart_tx_fifo #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .P_DATA(a_data), .DATA_VALID(a_valid),
        .PAR_EN(a_pe), .PAR_TYP(a_pt), .DATA_READY(a_ready),
        .TX_OUT(a_tx), .Busy(a_busy), .state_dbg(a_state)
    );

    uart_tx_fifo #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .P_DATA(b_data), .DATA_VALID(b_valid),
        .PAR_EN(b_pe), .PAR_TYP(b_pt), .DATA_READY(b_ready),
        .TX_OUT(b_tx), .Busy(b_busy), .state_dbg(b_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [7:0] d, input logic v,
                         input logic pe, input logic pt);
        if (sel) begin
            b_data = d; b_valid = v; b_pe = pe; b_pt = pt;
        end else begin
            a_data = d; a_valid = v; a_pe = pe; a_pt = pt;
        end
    endtask

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    // Next rising edge must be the first edge of the stream. Every cycle of
    // every queued bit is checked, then one idle cycle after the last stop.
    task automatic check_stream(input string tag, input bit sel);
        logic b;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, "_tx"}, sel ? b_tx : a_tx, b);
                chk({tag, "_busy"}, sel ? b_busy : a_busy, 1'b1);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_end_tx"}, sel ? b_tx : a_tx, 1'b1);
        chk({tag, "_end_busy"}, sel ? b_busy : a_busy, 1'b0);
        chk({tag, "_end_ready"}, sel ? b_ready : a_ready, 1'b1);
    endtask

    task automatic write_one(input bit sel, input logic [7:0] d,
                             input logic pe, input logic pt);
        @(negedge clk);
        drive(sel, d, 1'b1, pe, pt);
        @(posedge clk);
        #1;
        drive(sel, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", a_tx, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_ready", a_ready, 1'b1);
        chk3("rst_state", a_state, 3'd0);
        chk("rst_b_tx", b_tx, 1'b1);
        chk("rst_b_busy", b_busy, 1'b0);
        reset = 1'b0;

        // Idle line stays quiet
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx", a_tx, 1'b1);
            chk("idle_busy", a_busy, 1'b0);
        end

        // Even parity, A5 has four ones -> parity 0
        write_one(1'b0, 8'hA5, 1'b1, 1'b0);
        push_bits({5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        check_stream("even_a5", 1'b0);

        // Odd parity, 03 has two ones -> parity 1
        write_one(1'b0, 8'h03, 1'b1, 1'b1);
        push_bits({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        check_stream("odd_03", 1'b0);

        // No parity slot, 40-cycle frame
        write_one(1'b0, 8'h03, 1'b0, 1'b1);
        push_bits({6'b0, 1'b1, 8'h03, 1'b0}, 10);
        check_stream("nopar_03", 1'b0);

        // FIFO fill: six writes on consecutive edges, the sixth is dropped
        push_bits({6'b0, 1'b1, 8'h11, 1'b0}, 10);
        push_bits({6'b0, 1'b1, 8'h22, 1'b0}, 10);
        push_bits({6'b0, 1'b1, 8'h33, 1'b0}, 10);
        push_bits({6'b0, 1'b1, 8'h44, 1'b0}, 10);
        push_bits({6'b0, 1'b1, 8'h55, 1'b0}, 10);
        @(negedge clk);
        fork
            begin
                drive(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
                chk("fill_rdy1", a_ready, 1'b1);
                @(posedge clk); @(negedge clk);
                drive(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
                chk("fill_rdy2", a_ready, 1'b1);
                @(posedge clk); @(negedge clk);
                drive(1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
                chk("fill_rdy3", a_ready, 1'b1);
                @(posedge clk); @(negedge clk);
                drive(1'b0, 8'h44, 1'b1, 1'b0, 1'b0);
                chk("fill_rdy4", a_ready, 1'b1);
                @(posedge clk); @(negedge clk);
                drive(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
                chk("fill_rdy5", a_ready, 1'b1);
                @(posedge clk); @(negedge clk);
                drive(1'b0, 8'h66, 1'b1, 1'b1, 1'b1);
                chk("fill_rdy6_full", a_ready, 1'b0);
                @(posedge clk);
                #1;
                drive(1'b0, 8'hE7, 1'b0, 1'b1, 1'b0);
            end
            begin
                @(posedge clk);
                check_stream("fill", 1'b0);
            end
        join

        // Two stop bits, second word follows the stop bits directly
        push_bits({5'b0, 2'b11, 8'hFF, 1'b0}, 11);
        push_bits({5'b0, 2'b11, 8'h5A, 1'b0}, 11);
        @(negedge clk);
        fork
            begin
                drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
            end
            begin
                @(posedge clk);
                check_stream("stop2", 1'b1);
            end
        join

        // Reset during data bit 3 of the first of two queued words
        @(negedge clk);
        drive(1'b0, 8'h35, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("mid_bit3_tx", a_tx, 1'b0);
        chk("mid_bit3_busy", a_busy, 1'b1);
        chk3("mid_bit3_state", a_state, 3'd2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tx", a_tx, 1'b1);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_ready", a_ready, 1'b1);
        chk3("mid_rst_state", a_state, 3'd0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_rst_tx", a_tx, 1'b1);
            chk("post_rst_busy", a_busy, 1'b0);
        end

        // Fresh write after the abort, 96 has four ones -> even parity 0
        write_one(1'b0, 8'h96, 1'b1, 1'b0);
        push_bits({5'b0, 1'b1, 1'b0, 8'h96, 1'b0}, 11);
        check_stream("after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
